core_sfr_master: RTL

CORE_SFR_MASTER -- requirements
Module: core_sfr_master

---
 rtl/core_sfr_master_pkg.sv | 39 +++
 rtl/core_sfr_master_bit_mod.sv | 32 +++
 rtl/core_sfr_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/core_sfr_master_pkg.sv
// core_sfr_master_pkg
//   Shared opcode and state encodings for the SFR access master and its
//   bit-modify datapath, plus small decode helpers.
package core_sfr_master_pkg;

  typedef enum logic [2:0] {
    OP_RD_BYTE = 3'b000,
    OP_WR_BYTE = 3'b001,
    OP_RD_BIT  = 3'b010,
    OP_SET_BIT = 3'b011,
    OP_CLR_BIT = 3'b100,
    OP_CPL_BIT = 3'b101,
    OP_MOV_BIT = 3'b110,
    OP_RSVD    = 3'b111
  } sfr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5
  } sfr_state_e;

  // Bit addresses map onto the byte at the 8-aligned address below them.
  localparam logic [7:0] BIT_BYTE_MASK = 8'hF8;

  function automatic logic is_bit_op(input sfr_op_e op);
    return (op == OP_RD_BIT)  || (op == OP_SET_BIT) || (op == OP_CLR_BIT) ||
           (op == OP_CPL_BIT) || (op == OP_MOV_BIT);
  endfunction

  function automatic logic is_rmw_op(input sfr_op_e op);
    return (op == OP_SET_BIT) || (op == OP_CLR_BIT) ||
           (op == OP_CPL_BIT) || (op == OP_MOV_BIT);
  endfunction

endpackage

// File: rtl/core_sfr_master_bit_mod.sv
// core_sfr_bit_mod
//   Combinational bit-modify datapath: returns byte_i with bit idx_i set,
//   cleared, inverted or replaced by bit_i depending on op_i. Any other
//   opcode passes the byte through unchanged.
// Ports:
//   byte_i  in  8  byte read from the SFR
//   idx_i   in  3  bit index within the byte
//   op_i    in  3  operation code (sfr_op_e)
//   bit_i   in  1  replacement bit for MOV_BIT
//   byte_o  out 8  modified byte
module core_sfr_bit_mod
  import core_sfr_master_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic [2:0] idx_i,
  input  sfr_op_e    op_i,
  input  logic       bit_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = byte_i;
    case (op_i)
      OP_SET_BIT: byte_o[idx_i] = 1'b1;
      OP_CLR_BIT: byte_o[idx_i] = 1'b0;
      OP_CPL_BIT: byte_o[idx_i] = ~byte_i[idx_i];
      OP_MOV_BIT: byte_o[idx_i] = bit_i;
      default:    byte_o = byte_i;
    endcase
  end

endmodule

// File: rtl/core_sfr_master.sv
// core_sfr_master
//   Sequences single SFR accesses (byte read/write, bit read, bit
//   read-modify-write) onto the reg_ctrl strobe interface. Every output is
//   a flop loaded from the next-state decode, so nothing on the bus is
//   combinationally dependent on an input.
// Ports:
//   sfr_master_clk_i      in   1  core clock
//   sfr_master_reset_b_i  in   1  async reset, active low
//   sfr_master_req_i      in   1  access request, sampled in IDLE only
//   sfr_master_op_i       in   3  operation code
//   sfr_master_addr_i     in   8  SFR byte or bit address
//   sfr_master_wdata_i    in   8  byte write data
//   sfr_master_bit_i      in   1  bit value for MOV_BIT
//   sfr_master_busy_o     out  1  not idle
//   sfr_master_done_o     out  1  one-cycle completion pulse
//   sfr_master_err_o      out  1  illegal op/address, valid with done
//   sfr_master_rdata_o    out  8  captured read byte
//   sfr_master_rbit_o     out  1  captured read bit
//   sfr_master_wr_b_o     out  1  write strobe, active low
//   sfr_master_rd_b_o     out  1  read strobe, active low
//   sfr_master_byte_b_o   out  1  0 byte access, 1 bit/RMW access
//   sfr_master_addr_o     out  8  SFR byte address
//   sfr_master_data_o     out  8  SFR write data
//   sfr_master_data_i     in   8  SFR read data
//
// state     | meaning
// ST_IDLE   | waiting for req, bus outputs hold
// ST_RD     | rd strobe low, capture read byte/bit at closing edge
// ST_WR     | wr strobe low with the requested byte
// ST_RMW_RD | rd strobe low, capture byte and build the modified byte
// ST_RMW_WR | wr strobe low with the modified byte
// ST_DONE   | done pulse (with err on rejected requests)
module core_sfr_master
  import core_sfr_master_pkg::*;
#(
  parameter logic [7:0] SFR_BASE = 8'h80
) (
  input  logic       sfr_master_clk_i,
  input  logic       sfr_master_reset_b_i,
  input  logic       sfr_master_req_i,
  input  logic [2:0] sfr_master_op_i,
  input  logic [7:0] sfr_master_addr_i,
  input  logic [7:0] sfr_master_wdata_i,
  input  logic       sfr_master_bit_i,
  output logic       sfr_master_busy_o,
  output logic       sfr_master_done_o,
  output logic       sfr_master_err_o,
  output logic [7:0] sfr_master_rdata_o,
  output logic       sfr_master_rbit_o,
  output logic       sfr_master_wr_b_o,
  output logic       sfr_master_rd_b_o,
  output logic       sfr_master_byte_b_o,
  output logic [7:0] sfr_master_addr_o,
  output logic [7:0] sfr_master_data_o,
  input  logic [7:0] sfr_master_data_i
);

  sfr_state_e state_q, state_d;
  sfr_op_e    op_q, op_d;
  logic [2:0] idx_q, idx_d;
  logic       bit_q, bit_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rbit_q, rbit_d;
  logic       rd_b_q, rd_b_d;
  logic       wr_b_q, wr_b_d;
  logic       byte_b_q, byte_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  sfr_op_e    req_op;
  logic       req_bad;
  logic [7:0] mod_byte;

  assign req_op  = sfr_op_e'(sfr_master_op_i);
  assign req_bad = (req_op == OP_RSVD) || (sfr_master_addr_i < SFR_BASE);

  core_sfr_bit_mod u_bit_mod (
    .byte_i (sfr_master_data_i),
    .idx_i  (idx_q),
    .op_i   (op_q),
    .bit_i  (bit_q),
    .byte_o (mod_byte)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rbit_d   = rbit_q;
    byte_b_d = byte_b_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (sfr_master_req_i) begin
          op_d     = req_op;
          idx_d    = sfr_master_addr_i[2:0];
          bit_d    = sfr_master_bit_i;
          data_d   = sfr_master_wdata_i;
          byte_b_d = is_bit_op(req_op);
          addr_d   = is_bit_op(req_op) ? (sfr_master_addr_i & BIT_BYTE_MASK)
                                       : sfr_master_addr_i;
          err_d    = req_bad;
          if (req_bad) begin
            state_d = ST_DONE;
          end else if ((req_op == OP_RD_BYTE) || (req_op == OP_RD_BIT)) begin
            state_d = ST_RD;
          end else if (req_op == OP_WR_BYTE) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD: begin
        rdata_d = sfr_master_data_i;
        rbit_d  = sfr_master_data_i[idx_q];
        state_d = ST_DONE;
      end
      ST_WR: begin
        state_d = ST_DONE;
      end
      ST_RMW_RD: begin
        // The write phase drives the modified copy of the byte just read.
        rdata_d = sfr_master_data_i;
        rbit_d  = sfr_master_data_i[idx_q];
        data_d  = mod_byte;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Strobes and status are registered versions of the next-state decode.
    rd_b_d = !((state_d == ST_RD) || (state_d == ST_RMW_RD));
    wr_b_d = !((state_d == ST_WR) || (state_d == ST_RMW_WR));
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge sfr_master_clk_i or negedge sfr_master_reset_b_i) begin
    if (!sfr_master_reset_b_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_RD_BYTE;
      idx_q    <= 3'd0;
      bit_q    <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      rdata_q  <= 8'h00;
      rbit_q   <= 1'b0;
      rd_b_q   <= 1'b1;
      wr_b_q   <= 1'b1;
      byte_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      bit_q    <= bit_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rbit_q   <= rbit_d;
      rd_b_q   <= rd_b_d;
      wr_b_q   <= wr_b_d;
      byte_b_q <= byte_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sfr_master_busy_o   = busy_q;
  assign sfr_master_done_o   = done_q;
  assign sfr_master_err_o    = err_q;
  assign sfr_master_rdata_o  = rdata_q;
  assign sfr_master_rbit_o   = rbit_q;
  assign sfr_master_wr_b_o   = wr_b_q;
  assign sfr_master_rd_b_o   = rd_b_q;
  assign sfr_master_byte_b_o = byte_b_q;
  assign sfr_master_addr_o   = addr_q;
  assign sfr_master_data_o   = data_q;

endmodule
